nibble_serial_adder: RTL and testbench

- Multi-cycle N-bit adder sequencer built around one fourbits_adder instance.
- Captures two WIDTH-bit operands and a carry-in, then feeds the 4-bit adder one nibble per clock, LSB nibble first.
- Registers the nibble carry between cycles and assembles the WIDTH-bit sum.
- Sits between a valid/ready producer and consumer; area-cheap alternative to a WIDTH-bit ripple adder.

---
 rtl/nibble_serial_adder_pkg.sv | 18 +
 rtl/nibble_serial_adder_fourbits.sv | 13 +
 rtl/nibble_serial_adder.sv | 112 +++++++++++
 tb/tb_nibble_serial_adder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: nibble width, FSM states
// and the sizing helper for the nibble index register.
package nibble_serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A single-nibble adder still needs a one-bit index register.
    function automatic int idx_width(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_fourbits.sv
// Plain 4-bit ripple adder with carry in/out; the only arithmetic element
// of the nibble-serial adder.
module fourbits_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: captures operands over valid/ready, then adds
// one nibble per clock (LSB first) through a single 4-bit adder.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = idx_width(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    generate
        if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_width_check
            $fatal(1, "nibble_serial_adder: WIDTH must be a non-zero multiple of 4");
        end
    endgenerate

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             carry_reg;
    logic [IDX_W-1:0] idx;

    logic [NIBBLE_W-1:0] a_nib;
    logic [NIBBLE_W-1:0] b_nib;
    logic [NIBBLE_W-1:0] nib_sum;
    logic                nib_cout;
    logic                accept;
    logic                last_nib;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = !in_ready;
    assign sum       = sum_reg;
    assign cout      = carry_reg;

    assign accept   = in_valid && in_ready;
    assign last_nib = (idx == LAST_IDX);
    assign a_nib    = a_reg[idx*NIBBLE_W +: NIBBLE_W];
    assign b_nib    = b_reg[idx*NIBBLE_W +: NIBBLE_W];

    fourbits_adder u_nib_add (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry_reg),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept)    next_state = RUN;
            RUN:     if (last_nib)  next_state = DONE;
            DONE:    if (out_ready) next_state = IDLE;
            default:                next_state = IDLE;
        endcase
    end

    // The carry register doubles as cin on capture and as the nibble carry
    // while running, so after the last nibble it already holds cout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
        end else begin
            if (state == IDLE && accept) begin
                a_reg     <= a;
                b_reg     <= b;
                carry_reg <= cin;
                sum_reg   <= '0;
                idx       <= '0;
            end else if (state == RUN) begin
                sum_reg[idx*NIBBLE_W +: NIBBLE_W] <= nib_sum;
                carry_reg <= nib_cout;
                if (last_nib) begin
                    idx <= '0;
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16): directed scenarios
// plus randomized operands against a plain-arithmetic reference.
module tb_nibble_serial_adder;

    localparam int WIDTH   = 16;
    localparam int LATENCY = WIDTH / 4 + 1;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    int total = 0;
    int bad   = 0;
    int cycle = 0;

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + (WIDTH+1)'(c);
    endfunction

    // Drives one operand set from IDLE and returns #1 after the accepting edge.
    task automatic accept_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic c);
        int n;
        a = av; b = bv; cin = c; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int edges);
        edges = 0;
        while (!out_valid && edges < 20) begin
            @(posedge clk); #1; edges++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
        total++; if (sum !== 16'h0000) begin bad++; $display("[TB] FAIL reset_sum got=%h want=0000", sum); end
        total++; if (cout !== 1'b0) begin bad++; $display("[TB] FAIL reset_cout got=%b want=0", cout); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int e;
        out_ready = 1'b1;
        accept_op(16'h1234, 16'h1111, 1'b0);
        total++; if (busy !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("[TB] FAIL basic_busy got=%b/%b want=1/0", busy, in_ready); end
        wait_valid(e);
        total++; if (e + 1 != LATENCY) begin bad++; $display("[TB] FAIL basic_latency got=%0d want=%0d", e + 1, LATENCY); end
        total++; if (sum !== 16'h2345) begin bad++; $display("[TB] FAIL basic_sum got=%h want=2345", sum); end
        total++; if (cout !== 1'b0) begin bad++; $display("[TB] FAIL basic_cout got=%b want=0", cout); end
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("[TB] FAIL basic_release got=%b/%b want=1/0", in_ready, out_valid); end
    endtask

    task automatic test_carry();
        logic [WIDTH-1:0] av [2] = '{16'hFFFF, 16'hFFFF};
        logic [WIDTH-1:0] bv [2] = '{16'h0000, 16'hFFFF};
        logic [WIDTH-1:0] sv [2] = '{16'h0000, 16'hFFFF};
        logic [WIDTH:0]   r;
        int e;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            r = ref_add(av[i], bv[i], 1'b1);
            accept_op(av[i], bv[i], 1'b1);
            wait_valid(e);
            total++; if (sum !== sv[i] || sum !== r[WIDTH-1:0]) begin bad++; $display("[TB] FAIL carry_sum[%0d] got=%h want=%h", i, sum, sv[i]); end
            total++; if (cout !== 1'b1) begin bad++; $display("[TB] FAIL carry_cout[%0d] got=%b want=1", i, cout); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        int e;
        logic held_ok;
        out_ready = 1'b0;
        accept_op(16'h00FF, 16'h0001, 1'b0);
        in_valid = 1'b1; a = 16'hAAAA; b = 16'h5555; cin = 1'b1;
        wait_valid(e);
        total++; if (e + 1 != LATENCY) begin bad++; $display("[TB] FAIL bp_latency got=%0d want=%0d", e + 1, LATENCY); end
        held_ok = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || sum !== 16'h0100 || cout !== 1'b0 || in_ready !== 1'b0) held_ok = 1'b0;
        end
        total++; if (held_ok !== 1'b1) begin bad++; $display("[TB] FAIL bp_hold got=%b/%h/%b want=1/0100/0", out_valid, sum, cout); end
        out_ready = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("[TB] FAIL bp_release got=%b/%b want=1/0", in_ready, busy); end
        total++; if (sum !== 16'h0100) begin bad++; $display("[TB] FAIL bp_not_captured got=%h want=0100", sum); end
    endtask

    task automatic test_reset_mid_run();
        int e;
        logic quiet;
        out_ready = 1'b1;
        accept_op(16'h1234, 16'h4321, 1'b0);
        @(posedge clk); @(posedge clk);
        #2; rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("[TB] FAIL abort_flags got=%b/%b/%b want=0/1/0", out_valid, in_ready, busy); end
        total++; if (sum !== 16'h0000 || cout !== 1'b0) begin bad++; $display("[TB] FAIL abort_clear got=%h/%b want=0000/0", sum, cout); end
        @(negedge clk); rst_n = 1'b1;
        quiet = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) quiet = 1'b0;
        end
        total++; if (quiet !== 1'b1) begin bad++; $display("[TB] FAIL abort_no_valid got=0 want=1"); end
        accept_op(16'h0005, 16'h0003, 1'b0);
        wait_valid(e);
        total++; if (sum !== 16'h0008 || cout !== 1'b0) begin bad++; $display("[TB] FAIL after_abort got=%h/%b want=0008/0", sum, cout); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int e;
        int acc1;
        int acc2;
        out_ready = 1'b1;
        a = 16'h8000; b = 16'h8000; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        acc1 = cycle;
        a = 16'h0001; b = 16'h0002; cin = 1'b1;
        wait_valid(e);
        total++; if (sum !== 16'h0000 || cout !== 1'b1) begin bad++; $display("[TB] FAIL b2b_op1 got=%h/%b want=0000/1", sum, cout); end
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL b2b_idle got=%b want=1", in_ready); end
        @(posedge clk); #1;
        acc2 = cycle;
        in_valid = 1'b0;
        total++; if (acc2 - acc1 != 6 || busy !== 1'b1) begin bad++; $display("[TB] FAIL b2b_spacing got=%0d/%b want=6/1", acc2 - acc1, busy); end
        wait_valid(e);
        total++; if (sum !== 16'h0004 || cout !== 1'b0) begin bad++; $display("[TB] FAIL b2b_op2 got=%h/%b want=0004/0", sum, cout); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] av;
        logic [WIDTH-1:0] bv;
        logic             c;
        logic [WIDTH:0]   r;
        int e;
        for (int i = 0; i < 25; i++) begin
            av = WIDTH'($urandom);
            bv = WIDTH'($urandom);
            c  = 1'($urandom_range(0, 1));
            r  = ref_add(av, bv, c);
            out_ready = 1'b0;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            accept_op(av, bv, c);
            a = ~av; b = ~bv; cin = ~c; in_valid = 1'($urandom_range(0, 1));
            wait_valid(e);
            total++; if (e + 1 != LATENCY) begin bad++; $display("[TB] FAIL rnd_latency[%0d] got=%0d want=%0d", i, e + 1, LATENCY); end
            total++; if ({cout, sum} !== r) begin bad++; $display("[TB] FAIL rnd_result[%0d] got=%b/%h want=%b/%h", i, cout, sum, r[WIDTH], r[WIDTH-1:0]); end
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            out_ready = 1'b1; in_valid = 1'b0;
            @(posedge clk); #1;
            total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL rnd_release[%0d] got=%b want=1", i, in_ready); end
        end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
